// File: rtl/pic_pkg.sv
// Shared types and constants for the priority interrupt controller.
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } pic_state_t;

  // Word offsets inside the register window
  localparam logic [2:0] OFF_MASK = 3'd0;
  localparam logic [2:0] OFF_PEND = 3'd1;
  localparam logic [2:0] OFF_ISR  = 3'd2;
  localparam logic [2:0] OFF_VEC  = 3'd3;
  localparam logic [2:0] OFF_EOI  = 3'd4;

  // Vector value reported when an acknowledge finds no eligible source
  localparam logic [3:0] SPURIOUS_ID = 4'hF;

endpackage

// File: rtl/prio_enc8.sv
// 8-bit priority encoder: lowest set index wins, valid when any bit is set.
module prio_enc8 (
  input  logic [7:0] req_i,
  output logic       valid_o,
  output logic [2:0] idx_o
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    valid_o = |req_i;
    idx_o   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_i[i]) idx_o = 3'(i);
    end
  end

endmodule

// File: rtl/priority_int_ctrl.sv
// 8-input priority interrupt controller with a 5-word memory-mapped window.
// irq[0] is highest priority; one interrupt is in service at a time.
// Build option: define PIC_EDGE_EN for rising-edge capture of irq; without it
// the controller runs in level mode (pend follows irq every cycle).
// Handshake: int_o is held high until the CPU returns a one-cycle intack
// pulse; the acknowledge is only honoured while the controller is asserting.
module priority_int_ctrl
  import pic_pkg::*;
#(
  parameter logic [11:0] PIC_BASE = 12'hA00,
  parameter logic [7:0]  MASK_RST = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  irq,
  output logic        int_o,
  input  logic        intack,
  input  logic [11:0] address,
  input  logic [15:0] data_out,
  input  logic        memwt,
  output logic        rd_hit,
  output logic [15:0] data_rd
);

  pic_state_t  state_q, state_d;
  logic        int_q, int_d;
  logic [7:0]  pend_q, pend_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  isr_q, isr_d;
  logic [3:0]  vec_q, vec_d;

  logic [11:0] off;
  logic [2:0]  off_idx;
  logic        wr_mask, wr_eoi;
  logic        req;
  logic [2:0]  enc_idx;
  logic [7:0]  enc_onehot;
  logic        take_ack;
  logic        unused_hi;

`ifdef PIC_EDGE_EN
  logic [7:0]  irq_q, irq_d;
`endif

  assign unused_hi = ^data_out[15:8];

  // Address decode for the register window
  always_comb begin
    off     = address - PIC_BASE;
    off_idx = off[2:0];
    rd_hit  = (address >= PIC_BASE) && (off < 12'd5);
    wr_mask = memwt && rd_hit && (off_idx == OFF_MASK);
    wr_eoi  = memwt && rd_hit && (off_idx == OFF_EOI);
  end

  // Select the highest-priority unmasked pending source
  prio_enc8 u_enc (
    .req_i   (pend_q & ~mask_q),
    .valid_o (req),
    .idx_o   (enc_idx)
  );

  assign enc_onehot = 8'b1 << enc_idx;
  assign take_ack   = (state_q == ASSERT) && intack && req;

  // Read mux; EOI and out-of-window addresses read as zero
  always_comb begin
    data_rd = 16'h0000;
    if (rd_hit) begin
      case (off_idx)
        OFF_MASK: data_rd = {8'h00, mask_q};
        OFF_PEND: data_rd = {8'h00, pend_q};
        OFF_ISR:  data_rd = {8'h00, isr_q};
        OFF_VEC:  data_rd = {12'h000, vec_q};
        default:  data_rd = 16'h0000;
      endcase
    end
  end

  // Pending capture; in edge mode a new edge beats a same-cycle acknowledge clear
  always_comb begin
`ifdef PIC_EDGE_EN
    irq_d  = irq;
    pend_d = (pend_q & ~(take_ack ? enc_onehot : 8'h00)) | (irq & ~irq_q);
`else
    pend_d = irq;
`endif
  end

  // Controller FSM next state plus MASK/ISR/VEC updates
  always_comb begin
    state_d = state_q;
    int_d   = int_q;
    isr_d   = isr_q;
    vec_d   = vec_q;
    mask_d  = wr_mask ? data_out[7:0] : mask_q;
    case (state_q)
      IDLE: begin
        int_d = req;
        if (req) state_d = ASSERT;
      end
      ASSERT: begin
        if (take_ack) begin
          isr_d   = enc_onehot;
          vec_d   = {1'b0, enc_idx};
          int_d   = 1'b0;
          state_d = SERVICE;
        end else if (intack) begin
          vec_d   = SPURIOUS_ID;
          int_d   = 1'b0;
          state_d = IDLE;
        end else if (!req) begin
          int_d   = 1'b0;
          state_d = IDLE;
        end else begin
          int_d   = 1'b1;
        end
      end
      SERVICE: begin
        int_d = 1'b0;
        if (wr_eoi) begin
          isr_d   = 8'h00;
          state_d = IDLE;
        end
      end
      default: begin
        int_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      int_q   <= 1'b0;
      pend_q  <= 8'h00;
      mask_q  <= MASK_RST;
      isr_q   <= 8'h00;
      vec_q   <= SPURIOUS_ID;
`ifdef PIC_EDGE_EN
      irq_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      int_q   <= int_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      isr_q   <= isr_d;
      vec_q   <= vec_d;
`ifdef PIC_EDGE_EN
      irq_q   <= irq_d;
`endif
    end
  end

  assign int_o = int_q;

endmodule

// File: tb/tb_priority_int_ctrl.sv
// Testbench for priority_int_ctrl: directed scenarios plus randomized
// level-mode rounds, checked through an expected-value queue and a monitor.
module tb_priority_int_ctrl;

  localparam logic [11:0] BASE   = 12'hA00;
  localparam logic [11:0] A_MASK = BASE + 12'd0;
  localparam logic [11:0] A_PEND = BASE + 12'd1;
  localparam logic [11:0] A_ISR  = BASE + 12'd2;
  localparam logic [11:0] A_VEC  = BASE + 12'd3;
  localparam logic [11:0] A_EOI  = BASE + 12'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  irq = 8'h00;
  logic        int_o;
  logic        intack = 1'b0;
  logic [11:0] address = 12'h000;
  logic [15:0] data_out = 16'h0000;
  logic        memwt = 1'b0;
  logic        rd_hit;
  logic [15:0] data_rd;

  // check request from driver to monitor: kind 0 = data_rd, 1 = int_o, 2 = rd_hit
  logic        chk_req = 1'b0;
  int          chk_kind = 0;
  logic [15:0] exp_q[$];
  string       name_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] mon_act, mon_exp;
  string       mon_name;

  priority_int_ctrl #(.PIC_BASE(BASE), .MASK_RST(8'hFF)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq      (irq),
    .int_o    (int_o),
    .intack   (intack),
    .address  (address),
    .data_out (data_out),
    .memwt    (memwt),
    .rd_hit   (rd_hit),
    .data_rd  (data_rd)
  );

  // clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  // monitor: pops one expected value for every presented check
  always @(negedge clk) begin
    if (chk_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: check presented with empty expected queue");
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        case (chk_kind)
          0:       mon_act = data_rd;
          1:       mon_act = {15'h0, int_o};
          default: mon_act = {15'h0, rd_hit};
        endcase
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h at %0t", mon_name, mon_act, mon_exp, $time);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    irq = 8'h00;
    intack = 1'b0;
    memwt = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_reg(input logic [11:0] a, input logic [15:0] d);
    address  = a;
    data_out = d;
    memwt    = 1'b1;
    tick();
    memwt    = 1'b0;
  endtask

  task automatic issue(input int kind, input logic [11:0] a, input logic [15:0] e, input string n);
    address  = a;
    chk_kind = kind;
    exp_q.push_back(e);
    name_q.push_back(n);
    chk_req  = 1'b1;
    tick();
    chk_req  = 1'b0;
  endtask

  task automatic expect_reg(input logic [11:0] a, input logic [15:0] e, input string n);
    issue(0, a, e, n);
  endtask

  task automatic expect_int(input logic e, input string n);
    issue(1, address, {15'h0, e}, n);
  endtask

  task automatic pulse_ack();
    intack = 1'b1;
    tick();
    intack = 1'b0;
  endtask

  // reference: index of the highest-priority (lowest) set bit
  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 15;
  endfunction

  logic [7:0] rm, rv, el;
  logic [3:0] last_vec;
  int         n;

  initial begin
    // reset state and register window
    do_reset();
    expect_reg(A_MASK, 16'h00FF, "rst_mask");
    expect_reg(A_PEND, 16'h0000, "rst_pend");
    expect_reg(A_ISR,  16'h0000, "rst_isr");
    expect_reg(A_VEC,  16'h000F, "rst_vec");
    expect_reg(A_EOI,  16'h0000, "eoi_reads_zero");
    expect_int(1'b0, "rst_int");
    issue(2, 12'h123, 16'h0000, "rd_hit_outside");
    issue(0, 12'h123, 16'h0000, "data_rd_outside");
    issue(2, A_EOI, 16'h0001, "rd_hit_top");
    issue(2, BASE + 12'd5, 16'h0000, "rd_hit_past_top");
    write_reg(A_PEND, 16'h00FF);
    expect_reg(A_PEND, 16'h0000, "ro_pend_write");

    // 1: masked request is captured but not raised
    irq = 8'h04;
    tick();
    irq = 8'h00;
    expect_reg(A_PEND, 16'h0004, "t1_pend");
    expect_int(1'b0, "t1_int_a");
    expect_int(1'b0, "t1_int_b");

    // 2: unmasked irq[2] through acknowledge
    do_reset();
    write_reg(A_MASK, 16'h0000);
    irq = 8'h04;
    tick();
    expect_int(1'b0, "t2_int_lat1");
    expect_int(1'b1, "t2_int_lat2");
    pulse_ack();
    expect_int(1'b0, "t2_int_after_ack");
    expect_reg(A_VEC, 16'h0002, "t2_vec");
    expect_reg(A_ISR, 16'h0004, "t2_isr");
    irq = 8'h00;
    pulse_ack();
    expect_reg(A_VEC, 16'h0002, "t2_ack_in_service_ignored");
    write_reg(A_EOI, 16'h1234);
    expect_reg(A_ISR, 16'h0000, "t2_isr_after_eoi");
    expect_int(1'b0, "t2_int_idle");

    // 3: simultaneous irq[5] and irq[1]
    do_reset();
    write_reg(A_MASK, 16'h0000);
    irq = 8'h22;
    tick();
    expect_int(1'b0, "t3_lat1");
    expect_int(1'b1, "t3_lat2");
    pulse_ack();
    expect_reg(A_VEC, 16'h0001, "t3_vec_first");
    expect_reg(A_ISR, 16'h0002, "t3_isr_first");
    irq = 8'h20;
    write_reg(A_EOI, 16'h0000);
    expect_int(1'b0, "t3_reassert_lat1");
    expect_int(1'b1, "t3_reassert");
    pulse_ack();
    expect_reg(A_VEC, 16'h0005, "t3_vec_second");
    expect_reg(A_ISR, 16'h0020, "t3_isr_second");
    irq = 8'h00;
    write_reg(A_EOI, 16'h0000);

`ifndef PIC_EDGE_EN
    // 4: withdrawn level request and a late acknowledge
    do_reset();
    write_reg(A_MASK, 16'h0000);
    irq = 8'h08;
    tick();
    expect_int(1'b0, "t4_lat1");
    expect_int(1'b1, "t4_lat2");
    irq = 8'h00;
    tick();
    intack = 1'b1;
    expect_int(1'b1, "t4_still_high");
    intack = 1'b0;
    expect_int(1'b0, "t4_int_fell");
    expect_reg(A_VEC, 16'h000F, "t4_spurious_vec");
    expect_reg(A_ISR, 16'h0000, "t4_isr_zero");
`else
    // 5: repeated edges during service collapse into one pending bit
    do_reset();
    write_reg(A_MASK, 16'h0000);
    irq = 8'h40;
    tick();
    irq = 8'h00;
    expect_int(1'b0, "t5_lat1");
    expect_int(1'b1, "t5_lat2");
    pulse_ack();
    expect_reg(A_PEND, 16'h0000, "t5_pend_cleared");
    for (int k = 0; k < 2; k++) begin
      irq = 8'h40;
      tick();
      irq = 8'h00;
      tick();
    end
    expect_reg(A_PEND, 16'h0040, "t5_pend_once");
    expect_int(1'b0, "t5_no_int_in_service");
    write_reg(A_EOI, 16'h0000);
    expect_int(1'b0, "t5_eoi_lat1");
    expect_int(1'b1, "t5_second");
    pulse_ack();
    expect_reg(A_VEC, 16'h0006, "t5_vec");
    write_reg(A_EOI, 16'h0000);
    tick();
    tick();
    expect_int(1'b0, "t5_no_third");
    expect_reg(A_PEND, 16'h0000, "t5_pend_empty");
`endif

    // 6: reset while in service
    do_reset();
    write_reg(A_MASK, 16'h0000);
    irq = 8'h01;
    tick();
    tick();
    pulse_ack();
    expect_reg(A_ISR, 16'h0001, "t6_isr_before");
    rst = 1'b1;
    irq = 8'h00;
    tick();
    rst = 1'b0;
    expect_int(1'b0, "t6_int");
    expect_reg(A_ISR,  16'h0000, "t6_isr");
    expect_reg(A_PEND, 16'h0000, "t6_pend");
    expect_reg(A_MASK, 16'h00FF, "t6_mask");
    expect_reg(A_VEC,  16'h000F, "t6_vec");

`ifndef PIC_EDGE_EN
    // randomized level-mode rounds against the priority model
    last_vec = 4'hF;
    for (int r = 0; r < 24; r++) begin
      rm = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      rv = 8'($urandom_range(0, 255));
      el = rv & ~rm;
      irq = 8'h00;
      write_reg(A_MASK, {8'h00, rm});
      irq = rv;
      tick();
      expect_reg(A_PEND, {8'h00, rv}, "rnd_pend");
      expect_reg(A_MASK, {8'h00, rm}, "rnd_mask");
      expect_int(el != 8'h00, "rnd_int");
      pulse_ack();
      if (el != 8'h00) begin
        n = lowest(el);
        last_vec = 4'(n);
        expect_int(1'b0, "rnd_int_after_ack");
        expect_reg(A_VEC, {12'h000, last_vec}, "rnd_vec");
        expect_reg(A_ISR, 16'h0001 << n, "rnd_isr");
        write_reg(A_EOI, 16'($urandom_range(0, 65535)));
        expect_int(1'b0, "rnd_eoi_lat1");
        expect_int(1'b1, "rnd_reassert");
      end else begin
        expect_reg(A_VEC, {12'h000, last_vec}, "rnd_idle_ack_ignored");
        expect_reg(A_ISR, 16'h0000, "rnd_idle_isr");
      end
      irq = 8'h00;
      tick();
      tick();
      tick();
      expect_int(1'b0, "rnd_int_drop");
    end
`endif

    tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: %0d expected values unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
